// File: rtl/float_to_fixed_pipe_if.sv
// Handshake/data bundle between the angle source and float_to_fixed_pipe.
// master drives the float side; slave is the converter.
interface float_to_fixed_pipe_if #(
  parameter int DW = 32,
  parameter int W  = 22
);
  logic          clk_en;
  logic          in_valid;
  logic [DW-1:0] dataa;
  logic [W-1:0]  result;
  logic          out_valid;
  logic          sat;
  logic          nan;

  modport master (
    output clk_en, in_valid, dataa,
    input  result, out_valid, sat, nan
  );

  modport slave (
    input  clk_en, in_valid, dataa,
    output result, out_valid, sat, nan
  );
endinterface

// File: rtl/float_to_fixed_pipe.sv
// IEEE-754 single -> signed Q(INTEGER_WIDTH).(FRACTIONAL_WIDTH) with sat/nan flags; F2Q_ROUND_EN selects round-nearest-away, else truncate.
// Latency: 4 enabled cycles, one conversion per enabled cycle.
// Backpressure: none; clk_en=0 freezes every stage and the outputs.
module float_to_fixed_pipe #(
  parameter int FLOAT_DATA_WIDTH  = 32,
  parameter int INTEGER_WIDTH     = 2,
  parameter int FRACTIONAL_WIDTH  = 20,
  parameter int CORDIC_DATA_WIDTH = INTEGER_WIDTH + FRACTIONAL_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  float_to_fixed_pipe_if.slave io
);
  localparam int W    = CORDIC_DATA_WIDTH;
  localparam int WIDE = W + 26;
  localparam logic [W-1:0]    POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    NEG_MAX = ~POS_MAX + 1'b1;
  localparam logic [WIDE-1:0] LIMIT   = WIDE'(1) << (W-1);
  localparam logic [9:0]      SH_BIAS = 10'(FRACTIONAL_WIDTH - 150);
  localparam logic [9:0]      OVF_EXP = 10'(126 + INTEGER_WIDTH);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_NAN, CLS_INF} cls_t;

  logic        in_s;
  logic [7:0]  in_e;
  logic [22:0] in_f;
  cls_t        in_cls;

  assign in_s = io.dataa[FLOAT_DATA_WIDTH-1];
  assign in_e = io.dataa[FLOAT_DATA_WIDTH-2 -: 8];
  assign in_f = io.dataa[22:0];

  always_comb begin
    in_cls = CLS_NORM;
    if (in_e == 8'h00)
      in_cls = CLS_ZERO;
    else if (in_e == 8'hFF)
      in_cls = (in_f != 23'd0) ? CLS_NAN : CLS_INF;
  end

  // Stage 1: unpack
  logic        s1_vld, s1_s;
  logic [7:0]  s1_e;
  logic [23:0] s1_mant;
  cls_t        s1_cls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_s    <= 1'b0;
      s1_e    <= '0;
      s1_mant <= '0;
      s1_cls  <= CLS_ZERO;
    end else if (io.clk_en) begin
      s1_vld  <= io.in_valid;
      s1_s    <= in_s;
      s1_e    <= in_e;
      s1_mant <= {1'b1, in_f};
      s1_cls  <= in_cls;
    end
  end

  // Stage 2: alignment shift and early range check
  logic        s2_vld, s2_s, s2_ovf;
  logic [9:0]  s2_sh;
  logic [23:0] s2_mant;
  cls_t        s2_cls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld  <= 1'b0;
      s2_s    <= 1'b0;
      s2_ovf  <= 1'b0;
      s2_sh   <= '0;
      s2_mant <= '0;
      s2_cls  <= CLS_ZERO;
    end else if (io.clk_en) begin
      s2_vld  <= s1_vld;
      s2_s    <= s1_s;
      s2_ovf  <= {2'b00, s1_e} >= OVF_EXP;
      s2_sh   <= {2'b00, s1_e} + SH_BIAS;
      s2_mant <= s1_mant;
      s2_cls  <= s1_cls;
    end
  end

  // Stage 3: shift (wide enough that nothing falls off before the range check)
  logic [9:0]      rsh;
  logic [WIDE-1:0] wide;
  logic            mag_ovf;
`ifdef F2Q_ROUND_EN
  logic [4:0]      ridx;
`endif

  always_comb begin
    rsh  = 10'd0 - s2_sh;
    wide = '0;
`ifdef F2Q_ROUND_EN
    ridx = rsh[4:0] - 5'd1;
`endif
    if (!s2_sh[9]) begin
      wide = WIDE'(s2_mant) << s2_sh;
    end else if (rsh < 10'd25) begin
      wide = WIDE'(s2_mant >> rsh);
`ifdef F2Q_ROUND_EN
      wide = wide + WIDE'(s2_mant[ridx]);
`endif
    end
    mag_ovf = s2_ovf || (wide >= LIMIT);
  end

  logic         s3_vld, s3_s, s3_ovf;
  logic [W-1:0] s3_mag;
  cls_t         s3_cls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_vld <= 1'b0;
      s3_s   <= 1'b0;
      s3_ovf <= 1'b0;
      s3_mag <= '0;
      s3_cls <= CLS_ZERO;
    end else if (io.clk_en) begin
      s3_vld <= s2_vld;
      s3_s   <= s2_s;
      s3_ovf <= mag_ovf;
      s3_mag <= wide[W-1:0];
      s3_cls <= s2_cls;
    end
  end

  // Stage 4: sign, symmetric clamp and flags
  logic [W-1:0] nxt_res;
  logic         nxt_sat, nxt_nan;

  always_comb begin
    nxt_res = '0;
    nxt_sat = 1'b0;
    nxt_nan = 1'b0;
    case (s3_cls)
      CLS_NAN:  nxt_nan = 1'b1;
      CLS_INF:  begin
        nxt_sat = 1'b1;
        nxt_res = s3_s ? NEG_MAX : POS_MAX;
      end
      CLS_ZERO: nxt_res = '0;
      default: begin
        if (s3_ovf) begin
          nxt_sat = 1'b1;
          nxt_res = s3_s ? NEG_MAX : POS_MAX;
        end else begin
          nxt_res = s3_s ? (~s3_mag + 1'b1) : s3_mag;
        end
      end
    endcase
  end

  logic         out_vld, out_sat, out_nan;
  logic [W-1:0] out_res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      out_sat <= 1'b0;
      out_nan <= 1'b0;
      out_res <= '0;
    end else if (io.clk_en) begin
      out_vld <= s3_vld;
      out_sat <= s3_vld & nxt_sat;
      out_nan <= s3_vld & nxt_nan;
      out_res <= nxt_res;
    end
  end

  assign io.out_valid = out_vld;
  assign io.sat       = out_sat;
  assign io.nan       = out_nan;
  assign io.result    = out_res;
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Bench for float_to_fixed_pipe: directed test-plan vectors, stall/reset cases, then
// randomized traffic scored against a real-arithmetic reference with exact-latency tracking.
module tb_float_to_fixed_pipe;
  localparam int IW = 2;
  localparam int FW = 20;
  localparam int W  = IW + FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_to_fixed_pipe_if #(.DW(32), .W(W)) bus ();

  float_to_fixed_pipe #(
    .FLOAT_DATA_WIDTH (32),
    .INTEGER_WIDTH    (IW),
    .FRACTIONAL_WIDTH (FW),
    .CORDIC_DATA_WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         s;
    logic         n;
    int           t;
  } exp_t;

  exp_t q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  logic         last_v = 1'b0;
  logic [W-1:0] last_r = '0;
  logic         last_s = 1'b0;
  logic         last_n = 1'b0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic s, input logic n);
    exp_t e;
    e.r = r; e.s = s; e.n = n; e.t = 0;
    return e;
  endfunction

  // Value = 1.frac * 2^(e-127), scaled by 2^FW, then rounded/truncated and clamped.
  function automatic exp_t ref_model(input logic [31:0] f);
    exp_t e;
    int   p;
    int   mag;
    real  v;
    e = mk('0, 1'b0, 1'b0);
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 23'd0) e.n = 1'b1;
      else begin
        e.s = 1'b1;
        e.r = f[31] ? W'(1 - (1 << (W-1))) : W'((1 << (W-1)) - 1);
      end
    end else if (f[30:23] != 8'h00) begin
      p = int'(f[30:23]) - 150 + FW;
      if (p >= -24) begin
        v = real'(int'({1'b1, f[22:0]})) * (2.0 ** p);
`ifdef F2Q_ROUND_EN
        v = v + 0.5;
`endif
        if (v >= 2.0 ** (W-1)) begin
          e.s = 1'b1;
          e.r = f[31] ? W'(1 - (1 << (W-1))) : W'((1 << (W-1)) - 1);
        end else begin
          mag = $rtoi(v);
          e.r = f[31] ? W'(-mag) : W'(mag);
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic after_edge(input logic en);
    exp_t e;
    if (en) begin
      if (q.size() > 0 && q[0].t + 3 == edge_cnt) begin
        e = q.pop_front();
        chk("out_valid", W'(bus.out_valid), W'(1));
        chk("result", bus.result, e.r);
        chk("sat", W'(bus.sat), W'(e.s));
        chk("nan", W'(bus.nan), W'(e.n));
        last_v = 1'b1; last_r = e.r; last_s = e.s; last_n = e.n;
      end else begin
        chk("bubble_valid", W'(bus.out_valid), W'(0));
        last_v = 1'b0;
      end
    end else begin
      chk("stall_valid", W'(bus.out_valid), W'(last_v));
      if (last_v) begin
        chk("stall_result", bus.result, last_r);
        chk("stall_sat", W'(bus.sat), W'(last_s));
        chk("stall_nan", W'(bus.nan), W'(last_n));
      end
    end
  endtask

  task automatic step_x(input logic en, input logic vld, input logic [31:0] d, input exp_t e);
    exp_t x;
    bus.clk_en   = en;
    bus.in_valid = vld;
    bus.dataa    = d;
    @(posedge clk);
    #1;
    if (en) begin
      edge_cnt++;
      if (vld) begin
        x = e;
        x.t = edge_cnt;
        q.push_back(x);
      end
    end
    after_edge(en);
  endtask

  task automatic step(input logic en, input logic vld, input logic [31:0] d);
    step_x(en, vld, d, ref_model(d));
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  ex;
    int          sel;

    bus.clk_en = 1'b0; bus.in_valid = 1'b0; bus.dataa = '0;
    rst = 1'b0;
    #1;
    chk("rst_valid", W'(bus.out_valid), W'(0));
    chk("rst_result", bus.result, W'(0));
    chk("rst_sat", W'(bus.sat), W'(0));
    chk("rst_nan", W'(bus.nan), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Test-plan vectors, back to back
    step_x(1, 1, 32'h3F800000, mk(22'h100000, 0, 0));
    step_x(1, 1, 32'hBF000000, mk(22'h380000, 0, 0));
`ifdef F2Q_ROUND_EN
    step_x(1, 1, 32'h3F490FDB, mk(22'h0C90FE, 0, 0));
`else
    step_x(1, 1, 32'h3F490FDB, mk(22'h0C90FD, 0, 0));
`endif
    step_x(1, 1, 32'h40490FDB, mk(22'h1FFFFF, 1, 0));
    step_x(1, 1, 32'hC0000000, mk(22'h200001, 1, 0));
    step_x(1, 1, 32'hFF800000, mk(22'h200001, 1, 0));
    step_x(1, 1, 32'h7FC00000, mk(22'h000000, 0, 1));
    step_x(1, 1, 32'h00000001, mk(22'h000000, 0, 0));
    step_x(1, 1, 32'h80000000, mk(22'h000000, 0, 0));

    // Stall after the second of three inputs; stalled inputs must be ignored
    step_x(1, 1, 32'h3F800000, mk(22'h100000, 0, 0));
    step_x(1, 1, 32'hBF000000, mk(22'h380000, 0, 0));
    step(0, 1, 32'h3F000000);
    step(0, 1, 32'h3F000000);
    step_x(1, 1, 32'h3E800000, mk(22'h040000, 0, 0));
    repeat (4) step(1, 0, 32'h0);
    step(0, 0, 32'h0);

    // Reset with items in flight, one of them already on the outputs
    step(1, 1, 32'h3F800000);
    step(1, 1, 32'h3F000000);
    step(1, 1, 32'h3E800000);
    step(1, 1, 32'h3E000000);
    rst = 1'b0;
    #1;
    chk("flush_valid", W'(bus.out_valid), W'(0));
    chk("flush_result", bus.result, W'(0));
    chk("flush_sat", W'(bus.sat), W'(0));
    q.delete();
    last_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) step(1, 0, 32'h0);
    step_x(1, 1, 32'hBE800000, mk(22'h3C0000, 0, 0));
    repeat (4) step(1, 0, 32'h0);

    // Randomized traffic with random stalls and bubbles
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel < 6)       ex = 8'($urandom_range(100, 130));
      else if (sel == 6) ex = 8'h00;
      else if (sel == 7) ex = 8'hFF;
      else if (sel == 8) ex = 8'($urandom_range(1, 254));
      else               ex = 8'($urandom_range(126, 128));
      d[30:23] = ex;
      if (sel == 7 && d[0]) d[22:0] = '0;
      step(($urandom % 5) != 0, ($urandom % 4) != 0, d);
    end
    repeat (6) step(1, 0, 32'h0);
    chk("drain_empty", W'(q.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
